// File: rtl/lsb_embed_controller.sv
// rtl/lsb_embed_controller.sv - LSB steganography embedding sequencer with secret-byte FIFO
//
// Buffers UART secret bytes in a small FIFO and embeds them MSB-first into the
// LSB of a streamed image frame. Counts accepted image bytes and flags
// completion, FIFO overflow and capacity truncation.
//
// Optional feature macro: LSB_LEN_HDR_EN
//   defined   - a 16-bit header equal to secret_len is embedded before the payload
//   undefined - payload only
//
// Parameters:
//   TOTAL_BYTES  image bytes per frame (<= 65535)
//   FIFO_DEPTH   secret FIFO entries (power of two, >= 2)
//
// Ports:
//   clk, reset_n       clock, synchronous active-low reset
//   start              1-cycle frame start (ignored while busy)
//   secret_len         payload length in bytes, latched on accepted start
//   secret_valid/data  secret byte push into the FIFO
//   img_valid/data     image byte input
//   img_ready          image byte accepted this cycle
//   out_valid/data     embedded or pass-through byte, 1-cycle latency
//   busy               frame in progress
//   done               frame complete, held until next start or reset
//   fifo_full          secret FIFO full
//   overflow           sticky: secret byte dropped on full FIFO
//   trunc              sticky: frame ended with secret bits left over
//   bytes_processed    image bytes accepted this frame

module lsb_embed_fifo #(
  parameter int DEPTH = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       push,
  input  logic [7:0] din,
  input  logic       pop,
  output logic [7:0] head,
  output logic       empty,
  output logic       full
);
  localparam int AW = $clog2(DEPTH);

  logic [7:0]  mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end
endmodule

module lsb_embed_controller #(
  parameter int TOTAL_BYTES = 30000,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [15:0] secret_len,
  input  logic        secret_valid,
  input  logic [7:0]  secret_data,
  input  logic        img_valid,
  input  logic [7:0]  img_data,
  output logic        img_ready,
  output logic        out_valid,
  output logic [7:0]  out_data,
  output logic        busy,
  output logic        done,
  output logic        fifo_full,
  output logic        overflow,
  output logic        trunc,
  output logic [15:0] bytes_processed
);
  typedef enum logic [1:0] {IDLE, EMBED, PASS, DONE} state_t;

  localparam logic [15:0] LAST_BYTE = 16'(TOTAL_BYTES - 1);

  state_t      state;
  logic [18:0] bits_left;
  logic [6:0]  shift;
  logic [2:0]  shift_cnt;

  logic [7:0]  fifo_head;
  logic        fifo_empty;
  logic        fifo_push;
  logic        fifo_pop;
  logic        hs;
  logic        secret_bit;
  logic        hdr_active;
  logic        hdr_bit;
  logic        embed_ready;
  logic        start_ok;
  logic        last_byte;
  logic [18:0] len_bits;

`ifdef LSB_LEN_HDR_EN
  localparam logic [18:0] HDR_BITS = 19'd16;
  logic [15:0] hdr_shift;
  logic [4:0]  hdr_cnt;
  assign hdr_active = (hdr_cnt != 5'd0);
  assign hdr_bit    = hdr_shift[15];
`else
  localparam logic [18:0] HDR_BITS = 19'd0;
  assign hdr_active = 1'b0;
  assign hdr_bit    = 1'b0;
`endif

  // Header bits come from a register, so only payload bits can stall on the FIFO.
  assign embed_ready = hdr_active || (shift_cnt != 3'd0) || !fifo_empty;
  assign img_ready   = ((state == EMBED) && embed_ready) || (state == PASS);
  assign hs          = img_valid && img_ready;
  assign fifo_pop    = hs && (state == EMBED) && !hdr_active && (shift_cnt == 3'd0);
  // A push on a full FIFO still succeeds when the same cycle frees a slot.
  assign fifo_push   = secret_valid && (!fifo_full || fifo_pop);
  assign secret_bit  = hdr_active           ? hdr_bit  :
                       (shift_cnt != 3'd0)  ? shift[6] : fifo_head[7];
  assign start_ok    = start && ((state == IDLE) || (state == DONE));
  assign last_byte   = (bytes_processed == LAST_BYTE);
  assign len_bits    = {secret_len, 3'b000} + HDR_BITS;

  assign busy = (state == EMBED) || (state == PASS);
  assign done = (state == DONE);

  lsb_embed_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (fifo_push),
    .din     (secret_data),
    .pop     (fifo_pop),
    .head    (fifo_head),
    .empty   (fifo_empty),
    .full    (fifo_full)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state           <= IDLE;
      bits_left       <= '0;
      shift           <= '0;
      shift_cnt       <= '0;
      out_valid       <= 1'b0;
      out_data        <= '0;
      overflow        <= 1'b0;
      trunc           <= 1'b0;
      bytes_processed <= '0;
`ifdef LSB_LEN_HDR_EN
      hdr_shift       <= '0;
      hdr_cnt         <= '0;
`endif
    end else begin
      out_valid <= 1'b0;

      case (state)
        IDLE, DONE: begin
          if (start_ok) begin
            bytes_processed <= '0;
            overflow        <= 1'b0;
            trunc           <= 1'b0;
            // Leftover bits of a truncated byte belong to the previous frame.
            shift_cnt       <= '0;
            bits_left       <= len_bits;
            state           <= (len_bits != 19'd0) ? EMBED : PASS;
`ifdef LSB_LEN_HDR_EN
            hdr_shift       <= secret_len;
            hdr_cnt         <= 5'd16;
`endif
          end
        end

        EMBED: begin
          if (hs) begin
            out_valid       <= 1'b1;
            out_data        <= {img_data[7:1], secret_bit};
            bits_left       <= bits_left - 19'd1;
            bytes_processed <= bytes_processed + 16'd1;
            if (hdr_active) begin
`ifdef LSB_LEN_HDR_EN
              hdr_shift <= {hdr_shift[14:0], 1'b0};
              hdr_cnt   <= hdr_cnt - 5'd1;
`endif
            end else if (shift_cnt != 3'd0) begin
              shift     <= {shift[5:0], 1'b0};
              shift_cnt <= shift_cnt - 3'd1;
            end else begin
              shift     <= fifo_head[6:0];
              shift_cnt <= 3'd7;
            end
            if (last_byte) begin
              state <= DONE;
              // Truncated only if bits remain after this handshake's bit.
              trunc <= (bits_left != 19'd1);
            end else if (bits_left == 19'd1) begin
              state <= PASS;
            end
          end
        end

        PASS: begin
          if (hs) begin
            out_valid       <= 1'b1;
            out_data        <= img_data;
            bytes_processed <= bytes_processed + 16'd1;
            if (last_byte) state <= DONE;
          end
        end

        default: state <= IDLE;
      endcase

      // Placed last so a drop in the start cycle is not lost to the clear.
      if (secret_valid && fifo_full && !fifo_pop) overflow <= 1'b1;
    end
  end
endmodule

// File: tb/tb_lsb_embed_controller.sv
// tb/tb_lsb_embed_controller.sv - directed self-checking bench for lsb_embed_controller
module tb_lsb_embed_controller;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [15:0] secret_len;
  logic        secret_valid;
  logic [7:0]  secret_data;
  logic        img_valid;
  logic [7:0]  img_data;
  logic        img_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        busy;
  logic        done;
  logic        fifo_full;
  logic        overflow;
  logic        trunc;
  logic [15:0] bytes_processed;

  always #5 clk = ~clk;

  lsb_embed_controller #(.TOTAL_BYTES(20), .FIFO_DEPTH(4)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .start           (start),
    .secret_len      (secret_len),
    .secret_valid    (secret_valid),
    .secret_data     (secret_data),
    .img_valid       (img_valid),
    .img_data        (img_data),
    .img_ready       (img_ready),
    .out_valid       (out_valid),
    .out_data        (out_data),
    .busy            (busy),
    .done            (done),
    .fifo_full       (fifo_full),
    .overflow        (overflow),
    .trunc           (trunc),
    .bytes_processed (bytes_processed)
  );

  logic [7:0] got[$];
  logic [7:0] exp[$];
  int n_cmp = 0;
  int n_bad = 0;

  always @(negedge clk) if (out_valid) got.push_back(out_data);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    secret_valid = 1'b1;
    secret_data  = b;
    step();
    secret_valid = 1'b0;
  endtask

  task automatic start_frame(input logic [15:0] len);
    start      = 1'b1;
    secret_len = len;
    step();
    start      = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int i = 0;
    while (!done && i < 200) begin
      step();
      i++;
    end
    chk(tag, done, 1);
    step();
    img_valid = 1'b0;
  endtask

  task automatic chk_stream(input string tag);
    chk({tag, "_len"}, got.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got.size(); i++)
      chk($sformatf("%s[%0d]", tag, i), got[i], exp[i]);
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; secret_len = '0; secret_valid = 1'b0;
    secret_data = '0; img_valid = 1'b0; img_data = '0;
    step(2);
    chk("rst_img_ready", img_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_fifo_full", fifo_full, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_trunc", trunc, 0);
    chk("rst_bytes", bytes_processed, 0);
    reset_n = 1'b1;
    step();

`ifdef LSB_LEN_HDR_EN
    got.delete();
    push(8'hFF);
    img_valid = 1'b1; img_data = 8'h00;
    start_frame(16'd1);
    chk("h1_busy", busy, 1);
    wait_done("h1_done");
    exp.delete();
    repeat (15) exp.push_back(8'h00);
    repeat (5) exp.push_back(8'h01);
    chk_stream("h1_out");
    chk("h1_trunc", trunc, 1);

    got.delete();
    img_valid = 1'b1; img_data = 8'hFF;
    start_frame(16'd0);
    chk("h2_busy", busy, 1);
    wait_done("h2_done");
    exp.delete();
    repeat (16) exp.push_back(8'hFE);
    repeat (4) exp.push_back(8'hFF);
    chk_stream("h2_out");
    chk("h2_trunc", trunc, 0);
`else
    // Frame with two preloaded secret bytes
    got.delete();
    push(8'hA5);
    push(8'h3C);
    chk("t1_fifo_full", fifo_full, 0);
    img_valid = 1'b1; img_data = 8'hFF;
    start_frame(16'd2);
    chk("t1_busy", busy, 1);
    wait_done("t1_done");
    exp = '{8'hFF, 8'hFE, 8'hFF, 8'hFE, 8'hFE, 8'hFF, 8'hFE, 8'hFF,
            8'hFE, 8'hFE, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFE, 8'hFE,
            8'hFF, 8'hFF, 8'hFF, 8'hFF};
    chk_stream("t1_out");
    chk("t1_bytes", bytes_processed, 20);
    chk("t1_trunc", trunc, 0);
    chk("t1_busy_end", busy, 0);
    chk("t1_img_ready_done", img_ready, 0);

    // Stall on empty FIFO until a byte arrives
    chk("t2_done_held", done, 1);
    got.delete();
    img_valid = 1'b1; img_data = 8'h00;
    start_frame(16'd1);
    chk("t2_done_clr", done, 0);
    step(3);
    chk("t2_stall", img_ready, 0);
    chk("t2_stall_bytes", bytes_processed, 0);
    push(8'h80);
    wait_done("t2_done");
    exp.delete();
    exp.push_back(8'h01);
    repeat (19) exp.push_back(8'h00);
    chk_stream("t2_out");

    // Overflow on a depth-4 FIFO
    push(8'h11); push(8'h22); push(8'h33);
    chk("t3_not_full", fifo_full, 0);
    push(8'h44);
    chk("t3_full", fifo_full, 1);
    chk("t3_no_ovf", overflow, 0);
    push(8'h55);
    chk("t3_ovf", overflow, 1);

    // Capacity truncation: 32 bits into 20 bytes
    got.delete();
    img_valid = 1'b1; img_data = 8'h00;
    start_frame(16'd4);
    chk("t5_ovf_clr", overflow, 0);
    wait_done("t5_done");
    exp = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h01,
            8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00,
            8'h00, 8'h00, 8'h01, 8'h01};
    chk_stream("t5_out");
    chk("t5_trunc", trunc, 1);

    // Remaining FIFO byte is 0x44; 0x55 was dropped
    got.delete();
    img_valid = 1'b1; img_data = 8'h00;
    start_frame(16'd1);
    chk("t3_trunc_clr", trunc, 0);
    wait_done("t3_done");
    exp = '{8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00};
    repeat (12) exp.push_back(8'h00);
    chk_stream("t3_readout");
    img_valid = 1'b1; img_data = 8'hFF;
    start_frame(16'd1);
    step();
    chk("t3_fifo_drained", img_ready, 0);

    // Reset mid-frame after three handshakes
    push(8'h0F);
    push(8'hAA);
    step(2);
    chk("t4_bytes_pre", bytes_processed, 3);
    reset_n = 1'b0;
    step();
    chk("t4_busy", busy, 0);
    chk("t4_img_ready", img_ready, 0);
    chk("t4_out_valid", out_valid, 0);
    chk("t4_out_data", out_data, 0);
    chk("t4_bytes", bytes_processed, 0);
    chk("t4_done", done, 0);
    reset_n = 1'b1;
    got.delete();
    img_data = 8'hAA;
    start_frame(16'd1);
    step();
    chk("t4_fifo_empty", img_ready, 0);
    push(8'hC3);
    wait_done("t4_done_end");
    exp = '{8'hAB, 8'hAB, 8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAB, 8'hAB};
    repeat (12) exp.push_back(8'hAA);
    chk_stream("t4_out");
    chk("t4_bytes_end", bytes_processed, 20);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
